// File: rtl/dht11_sampler.sv
// Measurement scheduler for the dht11 driver: periodic/forced start pulses,
// watchdog, plausibility check, bounded retries and last-good-sample outputs.
module dht11_sampler #(
  parameter int unsigned PERIOD_CYCLES   = 100000000,
  parameter int unsigned RETRY_GAP       = 50000000,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned WATCHDOG_CYCLES = 5000000,
  parameter int unsigned HUM_MAX         = 100,
  parameter int unsigned TEMP_MAX        = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        force_meas,
  input  logic        dht_pronto,
  input  logic        dht_error,
  input  logic [15:0] dht_temperatura,
  input  logic [15:0] dht_umidade,
  output logic        dht_start,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic        valido,
  output logic        novo,
  output logic        falha,
  output logic [7:0]  erro_count,
  output logic [3:0]  db_estado
);

  localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam int WD_W  = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam int RT_W  = $clog2(MAX_RETRIES + 1);

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RETRY_GAP - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [RT_W-1:0]  RT_LIMIT = RT_W'(MAX_RETRIES);

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_TRIGGER     = 4'd1,
    ST_WAIT_RESULT = 4'd2,
    ST_CHECK       = 4'd3,
    ST_FAIL        = 4'd4,
    ST_GAP         = 4'd5,
    ST_PERIOD_WAIT = 4'd6
  } state_t;

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [RT_W-1:0]  retry_q, retry_d;
  logic [RT_W-1:0]  retry_inc;
  logic [7:0]       erro_q, erro_d;
  logic [15:0]      temp_q, temp_d;
  logic [15:0]      hum_q, hum_d;
  logic             valido_q, valido_d;
  logic             novo_q, novo_d;
  logic             falha_q, falha_d;
  logic             pronto_q, error_q;

  logic done_edge;
  logic fail_edge;
  logic range_ok;

  // Only rising edges count, so a flag left high by the previous read is ignored.
  assign done_edge = dht_pronto & ~pronto_q;
  assign fail_edge = dht_error & ~error_q;
  assign range_ok  = (32'(dht_umidade[15:8]) <= HUM_MAX) &&
                     (32'(dht_temperatura[15:8]) <= TEMP_MAX);

  always_comb begin
    state_d   = state_q;
    wd_cnt_d  = '0;
    gap_cnt_d = '0;
    per_cnt_d = '0;
    retry_d   = retry_q;
    retry_inc = retry_q + RT_W'(1);
    erro_d    = erro_q;
    temp_d    = temp_q;
    hum_d     = hum_q;
    valido_d  = valido_q;
    novo_d    = 1'b0;
    falha_d   = falha_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable || force_meas) state_d = ST_TRIGGER;
      end
      ST_TRIGGER: begin
        state_d = ST_WAIT_RESULT;
      end
      ST_WAIT_RESULT: begin
        wd_cnt_d = (wd_cnt_q == WD_LAST) ? '0 : wd_cnt_q + WD_W'(1);
        if (fail_edge)                state_d = ST_FAIL;
        else if (done_edge)           state_d = ST_CHECK;
        else if (wd_cnt_q == WD_LAST) state_d = ST_FAIL;
      end
      ST_CHECK: begin
        if (range_ok) begin
          temp_d   = dht_temperatura;
          hum_d    = dht_umidade;
          valido_d = 1'b1;
          novo_d   = 1'b1;
          falha_d  = 1'b0;
          retry_d  = '0;
          state_d  = enable ? ST_PERIOD_WAIT : ST_IDLE;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        erro_d = (erro_q == 8'hFF) ? erro_q : erro_q + 8'd1;
        if (retry_inc == RT_LIMIT) begin
          falha_d = 1'b1;
          retry_d = '0;
          state_d = enable ? ST_PERIOD_WAIT : ST_IDLE;
        end else begin
          // A started retry sequence runs to completion even if enable drops.
          retry_d = retry_inc;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_TRIGGER;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      ST_PERIOD_WAIT: begin
        if (!enable)                  state_d = ST_IDLE;
        else if (per_cnt_q == PER_LAST) state_d = ST_TRIGGER;
        else if (force_meas && (32'(per_cnt_q) >= RETRY_GAP)) state_d = ST_TRIGGER;
        else                          per_cnt_d = per_cnt_q + PER_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wd_cnt_q  <= '0;
      gap_cnt_q <= '0;
      per_cnt_q <= '0;
      retry_q   <= '0;
      erro_q    <= '0;
      temp_q    <= '0;
      hum_q     <= '0;
      valido_q  <= 1'b0;
      novo_q    <= 1'b0;
      falha_q   <= 1'b0;
      pronto_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_cnt_q  <= wd_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      per_cnt_q <= per_cnt_d;
      retry_q   <= retry_d;
      erro_q    <= erro_d;
      temp_q    <= temp_d;
      hum_q     <= hum_d;
      valido_q  <= valido_d;
      novo_q    <= novo_d;
      falha_q   <= falha_d;
      pronto_q  <= dht_pronto;
      error_q   <= dht_error;
    end
  end

  assign dht_start   = (state_q == ST_TRIGGER);
  assign temperatura = temp_q;
  assign umidade     = hum_q;
  assign valido      = valido_q;
  assign novo        = novo_q;
  assign falha       = falha_q;
  assign erro_count  = erro_q;
  assign db_estado   = state_q;

endmodule

// File: tb/tb_dht11_sampler.sv
// Directed bench for dht11_sampler: a vector table of single attempts plus
// hand-written sequences for retries, watchdog, reset and forced triggers.
module tb_dht11_sampler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        force_meas = 1'b0;
  logic        dht_pronto = 1'b0;
  logic        dht_error = 1'b0;
  logic [15:0] dht_temperatura = '0;
  logic [15:0] dht_umidade = '0;
  logic        dht_start;
  logic [15:0] temperatura;
  logic [15:0] umidade;
  logic        valido;
  logic        novo;
  logic        falha;
  logic [7:0]  erro_count;
  logic [3:0]  db_estado;

  dht11_sampler #(
    .PERIOD_CYCLES  (200),
    .RETRY_GAP      (20),
    .MAX_RETRIES    (3),
    .WATCHDOG_CYCLES(100),
    .HUM_MAX        (100),
    .TEMP_MAX       (50)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .force_meas     (force_meas),
    .dht_pronto     (dht_pronto),
    .dht_error      (dht_error),
    .dht_temperatura(dht_temperatura),
    .dht_umidade    (dht_umidade),
    .dht_start      (dht_start),
    .temperatura    (temperatura),
    .umidade        (umidade),
    .valido         (valido),
    .novo           (novo),
    .falha          (falha),
    .erro_count     (erro_count),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  // Driver model: kind 0 silent, 1 pronto, 2 error, 3 both.
  bit          model_en = 1'b1;
  int          model_kind = 1;
  int          model_delay = 10;
  logic [15:0] model_hum = '0;
  logic [15:0] model_temp = '0;
  int          timer = 0;

  int       start_count = 0;
  int       novo_count = 0;
  int       double_start = 0;
  int       last_start_cyc = 0;
  int       min_gap = 100000;
  int       check_cyc = 0;
  int       wait_entry_cyc = 0;
  int       fail_entry_cyc = 0;
  logic [3:0] prev_st = 4'd0;
  bit       prev_start = 1'b0;

  initial begin : model_and_monitor
    forever begin
      @(posedge clock);
      #1;
      if (dht_start) begin
        if (prev_start) double_start++;
        if (start_count > 0 && (cyc - last_start_cyc) < min_gap) min_gap = cyc - last_start_cyc;
        start_count++;
        last_start_cyc = cyc;
        if (model_en) begin
          dht_pronto = 1'b0;
          dht_error  = 1'b0;
          timer      = model_delay;
        end
      end else if (timer > 0) begin
        timer--;
        if (timer == 0 && model_en) begin
          dht_umidade     = model_hum;
          dht_temperatura = model_temp;
          dht_pronto      = (model_kind == 1 || model_kind == 3);
          dht_error       = (model_kind == 2 || model_kind == 3);
        end
      end
      prev_start = dht_start;
      if (novo) novo_count++;
      if (db_estado == 4'd3) check_cyc = cyc;
      if (db_estado == 4'd2 && prev_st != 4'd2) wait_entry_cyc = cyc;
      if (db_estado == 4'd4 && prev_st != 4'd4) fail_entry_cyc = cyc;
      prev_st = db_estado;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    enable     = 1'b0;
    force_meas = 1'b0;
    model_en   = 1'b1;
    timer      = 0;
    dht_pronto = 1'b0;
    dht_error  = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_force();
    force_meas = 1'b1;
    tick();
    force_meas = 1'b0;
  endtask

  task automatic wait_novo(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit && !ok; n++) begin
      tick();
      if (novo) ok = 1'b1;
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit && !ok; n++) begin
      tick();
      if (db_estado == st) ok = 1'b1;
    end
  endtask

  task automatic wait_erro(input logic [7:0] cnt, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit && !ok; n++) begin
      tick();
      if (erro_count == cnt) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [15:0] hum;
    logic [15:0] temp;
    int          kind;
    logic [3:0]  st;
    logic        val;
    logic        nv;
    logic [7:0]  err;
    logic [15:0] t_exp;
    logic [15:0] h_exp;
  } row_t;

  row_t rows[8];

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit ok;
    int base_start;
    int base_novo;
    int chk;
    int nc;

    rows[0] = '{16'h3A00, 16'h1905, 1, 4'd0, 1'b1, 1'b1, 8'd0, 16'h1905, 16'h3A00};
    rows[1] = '{16'h6400, 16'h3200, 1, 4'd0, 1'b1, 1'b1, 8'd0, 16'h3200, 16'h6400};
    rows[2] = '{16'h6500, 16'h1000, 1, 4'd5, 1'b0, 1'b0, 8'd1, 16'h0000, 16'h0000};
    rows[3] = '{16'h3000, 16'h3300, 1, 4'd5, 1'b0, 1'b0, 8'd1, 16'h0000, 16'h0000};
    rows[4] = '{16'h3000, 16'h1000, 2, 4'd5, 1'b0, 1'b0, 8'd1, 16'h0000, 16'h0000};
    rows[5] = '{16'h3000, 16'h1000, 3, 4'd5, 1'b0, 1'b0, 8'd1, 16'h0000, 16'h0000};
    rows[6] = '{16'h3000, 16'h1000, 0, 4'd5, 1'b0, 1'b0, 8'd1, 16'h0000, 16'h0000};
    rows[7] = '{16'h00FF, 16'h00AA, 1, 4'd0, 1'b1, 1'b1, 8'd0, 16'h00AA, 16'h00FF};

    // Reset with random inputs, then the first start pulse.
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      enable          = 1'($urandom);
      force_meas      = 1'($urandom);
      dht_pronto      = 1'($urandom);
      dht_error       = 1'($urandom);
      dht_umidade     = 16'($urandom);
      dht_temperatura = 16'($urandom);
      tick();
    end
    check("rst_estado", 32'(db_estado), 32'd0);
    check("rst_start", 32'(dht_start), 32'd0);
    check("rst_outputs", {temperatura, umidade}, 32'd0);
    check("rst_flags", {21'd0, valido, novo, falha, erro_count}, 32'd0);
    enable = 1'b0; force_meas = 1'b0; dht_pronto = 1'b0; dht_error = 1'b0;
    model_en = 1'b1; model_kind = 1; model_delay = 30;
    model_hum = 16'h3A00; model_temp = 16'h1905;
    reset = 1'b1;
    tick();
    check("idle_after_release", 32'(db_estado), 32'd0);
    enable = 1'b1;
    tick();
    check("start_first_cycle", 32'(dht_start), 32'd1);
    tick();
    check("start_second_cycle", 32'(dht_start), 32'd0);

    // Good read and period spacing.
    wait_novo(100, ok);
    check("good_novo_seen", 32'(ok), 32'd1);
    check("good_umidade", 32'(umidade), 32'h3A00);
    check("good_temperatura", 32'(temperatura), 32'h1905);
    check("good_valido", 32'(valido), 32'd1);
    check("good_estado_pw", 32'(db_estado), 32'd6);
    tick();
    check("novo_single_cycle", 32'(novo), 32'd0);
    chk = check_cyc;
    model_kind = 2; model_delay = 3;
    base_start = start_count;
    min_gap = 100000;
    ok = 1'b0;
    for (int n = 0; n < 250 && !ok; n++) begin
      tick();
      if (dht_start) ok = 1'b1;
    end
    check("period_start_seen", 32'(ok), 32'd1);
    check("period_spacing", 32'(cyc - chk), 32'd201);

    // Repeated driver error exhausts retries.
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      tick();
      if (falha) ok = 1'b1;
    end
    check("err_falha_seen", 32'(ok), 32'd1);
    check("err_start_pulses", 32'(start_count - base_start), 32'd3);
    check("err_min_spacing_ok", 32'(min_gap >= 21), 32'd1);
    check("err_erro_count", 32'(erro_count), 32'd3);
    check("err_valido_kept", 32'(valido), 32'd1);
    check("err_data_kept", {temperatura, umidade}, 32'h19053A00);
    check("err_estado_pw", 32'(db_estado), 32'd6);
    check("err_no_double_start", 32'(double_start), 32'd0);
    model_kind = 1; model_delay = 10;
    wait_novo(300, ok);
    check("err_recovery_novo", 32'(ok), 32'd1);
    check("err_recovery_falha", 32'(falha), 32'd0);

    // Table of single forced attempts with enable low.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      model_kind = rows[i].kind; model_delay = 10;
      model_hum = rows[i].hum; model_temp = rows[i].temp;
      pulse_force();
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
        tick();
        if (db_estado == 4'd0 || db_estado == 4'd5) ok = 1'b1;
      end
      $display("[TB] row %0d hum=%h temp=%h kind=%0d -> estado=%0d valido=%0d erro=%0d", i,
               rows[i].hum, rows[i].temp, rows[i].kind, db_estado, valido, erro_count);
      check($sformatf("row%0d_done", i), 32'(ok), 32'd1);
      check($sformatf("row%0d_estado", i), 32'(db_estado), 32'(rows[i].st));
      check($sformatf("row%0d_flags", i), {30'd0, valido, novo}, {30'd0, rows[i].val, rows[i].nv});
      check($sformatf("row%0d_erro", i), 32'(erro_count), 32'(rows[i].err));
      check($sformatf("row%0d_data", i), {temperatura, umidade}, {rows[i].t_exp, rows[i].h_exp});
    end

    // Range failure, then recovery with retry count cleared.
    do_reset();
    model_kind = 1; model_delay = 10; model_hum = 16'h6500; model_temp = 16'h1000;
    enable = 1'b1;
    wait_erro(8'd1, 100, ok);
    check("range_fail_seen", 32'(ok), 32'd1);
    check("range_fail_gap", 32'(db_estado), 32'd5);
    check("range_fail_valido", 32'(valido), 32'd0);
    model_hum = 16'h3000;
    wait_novo(100, ok);
    check("range_recover_novo", 32'(ok), 32'd1);
    check("range_recover_data", {temperatura, umidade}, 32'h10003000);
    check("range_recover_falha", 32'(falha), 32'd0);
    check("range_recover_erro", 32'(erro_count), 32'd1);
    model_kind = 2; model_delay = 3;
    wait_erro(8'd3, 400, ok);
    check("retry_reset_seen", 32'(ok), 32'd1);
    check("retry_reset_no_falha", 32'(falha), 32'd0);
    wait_erro(8'd4, 100, ok);
    check("retry_third_seen", 32'(ok), 32'd1);
    check("retry_third_falha", 32'(falha), 32'd1);

    // Watchdog timing.
    do_reset();
    model_kind = 0;
    pulse_force();
    wait_state(4'd4, 200, ok);
    check("wd_fail_seen", 32'(ok), 32'd1);
    check("wd_latency", 32'(fail_entry_cyc - wait_entry_cyc), 32'd100);

    // Pronto held high across the start is never a done edge.
    do_reset();
    model_en = 1'b0;
    dht_umidade = 16'h1000; dht_temperatura = 16'h1000;
    dht_pronto = 1'b1;
    base_novo = novo_count;
    tick();
    pulse_force();
    wait_state(4'd4, 200, ok);
    check("held_fail_seen", 32'(ok), 32'd1);
    check("held_no_novo", 32'(novo_count - base_novo), 32'd0);
    tick();
    check("held_erro", 32'(erro_count), 32'd1);
    check("held_valido", 32'(valido), 32'd0);

    // Async reset in WAIT_RESULT with pronto high at release.
    do_reset();
    model_kind = 1; model_delay = 10; model_hum = 16'h2000; model_temp = 16'h1500;
    enable = 1'b1;
    wait_novo(100, ok);
    check("rstmid_first_novo", 32'(ok), 32'd1);
    wait_state(4'd2, 250, ok);
    check("rstmid_wait_seen", 32'(ok), 32'd1);
    model_en = 1'b0;
    reset = 1'b0;
    dht_pronto = 1'b1;
    #1;
    check("rstmid_estado", 32'(db_estado), 32'd0);
    check("rstmid_outputs", {temperatura, umidade}, 32'd0);
    check("rstmid_flags", {21'd0, valido, novo, falha, erro_count}, 32'd0);
    tick();
    base_novo = novo_count;
    reset = 1'b1;
    for (int n = 0; n < 150; n++) tick();
    check("rstmid_no_accept", 32'(novo_count - base_novo), 32'd0);
    check("rstmid_valido", 32'(valido), 32'd0);
    check("rstmid_erro", 32'(erro_count), 32'd1);

    // Forced trigger during PERIOD_WAIT respects the retry spacing.
    do_reset();
    model_kind = 1; model_delay = 5; model_hum = 16'h2000; model_temp = 16'h1500;
    enable = 1'b1;
    wait_novo(50, ok);
    check("force_novo_seen", 32'(ok), 32'd1);
    nc = cyc;
    while (cyc < nc + 10) tick();
    pulse_force();
    check("force_at10_ignored", 32'(db_estado), 32'd6);
    while (cyc < nc + 25) tick();
    pulse_force();
    check("force_at25_trigger", 32'(db_estado), 32'd1);
    check("force_at25_start", 32'(dht_start), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
